// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive port: FSM state encoding,
// STATUS register layout and register-select constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rxState_t;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 7;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    function automatic logic [31:0] packStatus(
        input logic                  notEmpty,
        input logic                  full,
        input logic                  overrun,
        input logic                  frameErr,
        input logic [ST_COUNT_W-1:0] count
    );
        logic [31:0] w;
        w = '0;
        w[ST_NOT_EMPTY] = notEmpty;
        w[ST_FULL]      = full;
        w[ST_OVERRUN]   = overrun;
        w[ST_FRAME_ERR] = frameErr;
        w[ST_COUNT_LSB +: ST_COUNT_W] = count;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; a push while full is
// only accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || pop);
    assign dout   = mem[rdPtr];

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver: mid-bit sampling FSM feeding a FIFO,
// with DATA (pop) and STATUS (read-to-clear flags) registers on the IO bus.
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RXD,
    input  logic        sel,
    input  logic        regSel,
    input  logic        memRstrb,
    output logic [31:0] memRData,
    output logic        rxStrobe,
    output logic [7:0]  rxByte
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxMeta;
    logic             rxs;
    rxState_t         state,  stateNext;
    logic [CNT_W-1:0] cnt,    cntNext;
    logic [2:0]       bitIdx, bitNext;
    logic [7:0]       shift,  shiftNext;
    logic             byteDone;
    logic             frameErrSet;

    logic             overrun;
    logic             frameErr;
    logic             readData;
    logic             readStatus;
    logic             fifoPop;
    logic [7:0]       fifoDout;
    logic             fifoEmpty;
    logic             fifoFull;
    logic [CW-1:0]    fifoCount;

    // Synchronizer idles high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxMeta <= RXD;
            rxs    <= rxMeta;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bitIdx <= '0;
            shift  <= '0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            bitIdx <= bitNext;
            shift  <= shiftNext;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        bitNext     = bitIdx;
        shiftNext   = shift;
        byteDone    = 1'b0;
        frameErrSet = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    stateNext = START;
                    cntNext   = HALF_RELOAD;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cntNext = cnt - CNT_W'(1);
                end else if (!rxs) begin
                    stateNext = DATA;
                    cntNext   = FULL_RELOAD;
                    bitNext   = 3'd0;
                end else begin
                    stateNext = IDLE;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cntNext = cnt - CNT_W'(1);
                end else begin
                    shiftNext[bitIdx] = rxs;
                    cntNext           = FULL_RELOAD;
                    if (bitIdx == 3'd7) stateNext = STOP;
                    else                bitNext   = bitIdx + 3'd1;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cntNext = cnt - CNT_W'(1);
                end else if (rxs) begin
                    byteDone  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    frameErrSet = 1'b1;
                    stateNext   = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rxs) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign readData   = sel && memRstrb && (regSel == REG_DATA);
    assign readStatus = sel && memRstrb && (regSel == REG_STATUS);
    assign fifoPop    = readData && !fifoEmpty;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (byteDone),
        .pop   (fifoPop),
        .din   (shift),
        .dout  (fifoDout),
        .empty (fifoEmpty),
        .full  (fifoFull),
        .count (fifoCount)
    );

    // A flag set in the same cycle as a STATUS read survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            memRData <= '0;
            rxStrobe <= 1'b0;
            rxByte   <= '0;
            overrun  <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            rxStrobe <= byteDone;
            if (byteDone) rxByte <= shift;
            overrun  <= (byteDone && fifoFull && !fifoPop) || (overrun && !readStatus);
            frameErr <= frameErrSet || (frameErr && !readStatus);
            if (readData) begin
                memRData <= fifoEmpty ? 32'd0 : {24'd0, fifoDout};
            end else if (readStatus) begin
                memRData <= packStatus(!fifoEmpty, fifoFull, overrun, frameErr,
                                       ST_COUNT_W'(fifoCount));
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_port.sv
// Randomized scoreboard bench for uart_rx_port with a queue-based reference
// model; monitors pop expected read data and received bytes independently.
module tb_uart_rx_port;
    import uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        RXD;
    logic        sel;
    logic        regSel;
    logic        memRstrb;
    logic [31:0] memRData;
    logic        rxStrobe;
    logic [7:0]  rxByte;

    int tests = 0;
    int fails = 0;

    logic [7:0]  fifoModel[$];
    logic [7:0]  strobeQ[$];
    logic [31:0] readQ[$];
    bit          ovrM;
    bit          feM;
    logic        pend = 1'b0;

    uart_rx_port #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .RXD     (RXD),
        .sel     (sel),
        .regSel  (regSel),
        .memRstrb(memRstrb),
        .memRData(memRData),
        .rxStrobe(rxStrobe),
        .rxByte  (rxByte)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [31:0] modelStatus();
        int n;
        n = fifoModel.size();
        return 32'(n * 16 + (feM ? 8 : 0) + (ovrM ? 4 : 0) + ((n == DEPTH) ? 2 : 0) + ((n != 0) ? 1 : 0));
    endfunction

    // Reference for one bus read: records the expected data and applies side effects.
    task automatic modelRead(input bit isStatus);
        logic [31:0] exp;
        if (isStatus) begin
            exp  = modelStatus();
            ovrM = 1'b0;
            feM  = 1'b0;
        end else if (fifoModel.size() > 0) begin
            exp = {24'd0, fifoModel.pop_front()};
        end else begin
            exp = 32'd0;
        end
        readQ.push_back(exp);
    endtask

    task automatic doRead(input bit isStatus);
        modelRead(isStatus);
        sel = 1'b1; memRstrb = 1'b1; regSel = isStatus;
        tick();
        sel = 1'b0; memRstrb = 1'b0; regSel = 1'b0;
        tick();
    endtask

    task automatic modelReset();
        fifoModel.delete();
        ovrM = 1'b0;
        feM  = 1'b0;
    endtask

    // Drives one 8N1 frame; abortAt>0 pulses reset that many cycles in,
    // readAtStop lines a DATA read up with the stop-bit sample.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit,
                             input int abortAt, input bit readAtStop);
        logic [9:0] bits;
        int cyc;
        bits = {stopBit, b, 1'b0};
        cyc  = 0;
        for (int i = 0; i < 10; i++) begin
            RXD = bits[i];
            for (int c = 0; c < CPB; c++) begin
                if (abortAt > 0 && cyc == abortAt) begin
                    reset = 1'b1;
                    RXD   = 1'b1;
                    tick();
                    tick();
                    reset = 1'b0;
                    modelReset();
                    return;
                end
                tick();
                cyc++;
            end
        end
        if (readAtStop) begin
            modelRead(1'b0);
            sel = 1'b1; memRstrb = 1'b1; regSel = 1'b0;
        end
        if (stopBit) begin
            strobeQ.push_back(b);
            if (fifoModel.size() == DEPTH) ovrM = 1'b1;
            else                           fifoModel.push_back(b);
        end else begin
            feM = 1'b1;
        end
        if (readAtStop) begin
            tick();
            sel = 1'b0; memRstrb = 1'b0;
        end
        if (stopBit) idle(CPB);
    endtask

    always @(posedge clk) pend <= sel && memRstrb && !reset;

    always @(negedge clk) begin
        if (pend) begin
            if (readQ.size() == 0) begin
                tests++; fails++;
                $display("FAIL memRData: got unexpected read 0x%0h, expected none", memRData);
            end else begin
                check("memRData", memRData, readQ.pop_front());
            end
        end
        if (rxStrobe) begin
            if (strobeQ.size() == 0) begin
                tests++; fails++;
                $display("FAIL rxStrobe: got pulse with rxByte 0x%0h, expected none", rxByte);
            end else begin
                check("rxByte", {24'd0, rxByte}, {24'd0, strobeQ.pop_front()});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; RXD = 1'b1; sel = 1'b0; regSel = 1'b0; memRstrb = 1'b0;
        modelReset();
        idle(3);
        reset = 1'b0;
        tick();
        check("reset memRData", memRData, 32'd0);
        check("reset rxStrobe", {31'd0, rxStrobe}, 32'd0);
        check("reset rxByte", {24'd0, rxByte}, 32'd0);
        doRead(1'b1);

        // Two bytes, then drain.
        sendFrame(8'hA5, 1'b1, 0, 1'b0);
        sendFrame(8'h3C, 1'b1, 0, 1'b0);
        check("rxByte hold", {24'd0, rxByte}, 32'h3C);
        doRead(1'b1);
        doRead(1'b0);
        doRead(1'b0);
        idle(5);
        check("memRData hold", memRData, 32'h3C);
        doRead(1'b1);
        doRead(1'b0);

        // Overrun on the fifth byte.
        for (int i = 1; i <= 5; i++) sendFrame(8'(i), 1'b1, 0, 1'b0);
        doRead(1'b1);
        repeat (4) doRead(1'b0);
        doRead(1'b1);

        // Framing error followed by a held break.
        sendFrame(8'h55, 1'b0, 0, 1'b0);
        idle(40);
        check("break state", {29'd0, dut.state}, {29'd0, WAIT_HIGH});
        doRead(1'b1);
        check("break no retrigger", {29'd0, dut.state}, {29'd0, WAIT_HIGH});
        RXD = 1'b1;
        idle(6);
        sendFrame(8'h77, 1'b1, 0, 1'b0);
        doRead(1'b1);
        doRead(1'b0);

        // One-cycle glitch.
        RXD = 1'b0;
        tick();
        RXD = 1'b1;
        idle(10);
        doRead(1'b1);

        // Full FIFO with a pop coinciding with the push.
        for (int i = 0; i < 4; i++) sendFrame(8'h10 + 8'(i), 1'b1, 0, 1'b0);
        sendFrame(8'h14, 1'b1, 0, 1'b1);
        doRead(1'b1);
        repeat (5) doRead(1'b0);

        // Reset during data bit 3.
        sendFrame(8'h9A, 1'b1, 0, 1'b0);
        sendFrame(8'hFF, 1'b1, 19, 1'b0);
        tick();
        check("abort memRData", memRData, 32'd0);
        check("abort rxByte", {24'd0, rxByte}, 32'd0);
        check("abort rxStrobe", {31'd0, rxStrobe}, 32'd0);
        idle(4);
        doRead(1'b1);
        sendFrame(8'h12, 1'b1, 0, 1'b0);
        doRead(1'b0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    if ($urandom_range(0, 7) == 0) begin
                        sendFrame(8'($urandom), 1'b0, 0, 1'b0);
                        RXD = 1'b1;
                        idle(CPB);
                    end else begin
                        sendFrame(8'($urandom), 1'b1, 0, 1'b0);
                    end
                    idle($urandom_range(0, 6));
                end
                2:       doRead(1'b0);
                default: doRead(1'b1);
            endcase
        end
        doRead(1'b1);
        idle(10);
        check("strobe queue drained", 32'(strobeQ.size()), 32'd0);
        check("read queue drained", 32'(readQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
